multdiv_unit: RTL

- Iterative signed multiply/divide unit attached to the execute stage of the pipelined processor; parametrised in operand width.
- Executes mul/div instructions over WIDTH cycles.
- Drives `busy` so the hazard logic can freeze the PC, F/D and D/X latches while an operation is in flight.
- Returns a registered result, a one-cycle ready strobe and an exception flag for the writeback path.

---
 rtl/multdiv_unit_pkg.sv | 14 +
 rtl/multdiv_unit_if.sv | 33 +++
 rtl/multdiv_unit_iter_step.sv | 36 +++
 rtl/multdiv_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// Processor-wide constants shared by the mul/div unit.
// Holds the word size and the FSM state encoding.
package multdiv_unit_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } md_state_e;

endpackage

// File: rtl/multdiv_unit_if.sv
// Request/response bundle between execute stage and mul/div unit.
// The master drives requests; the slave returns result and status.
interface multdiv_unit_if
   import multdiv_unit_pkg::*;
#(
   parameter int WIDTH = XLEN
);

   logic             ctrl_mult;
   logic             ctrl_div;
   logic             flush;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_mult, ctrl_div, flush,
      output data_operandA, data_operandB,
      input  data_result, data_exception,
      input  data_resultRDY, busy
   );

   modport slave (
      input  ctrl_mult, ctrl_div, flush,
      input  data_operandA, data_operandB,
      output data_result, data_exception,
      output data_resultRDY, busy
   );

endinterface

// File: rtl/multdiv_unit_iter_step.sv
// One iteration of shift-add multiply or restoring divide.
// acc holds {hi, multiplier} for mult and {rem, quotient} for div.
module multdiv_iter_step
   import multdiv_unit_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opnd_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] rem_sh;
   logic [WIDTH:0]   trial;

   // Remainder stays below the divisor, so its top bit is always 0.
   always_comb begin
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
      rem_sh = {acc_i[2*WIDTH-2:WIDTH], acc_i[WIDTH-1]};
      trial  = {1'b0, rem_sh} - {1'b0, opnd_i};
      acc_o  = '0;
      if (is_div) begin
         if (trial[WIDTH])
            acc_o = {rem_sh, acc_i[WIDTH-2:0], 1'b0};
         else
            acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else if (acc_i[0]) begin
         acc_o = {sum, acc_i[WIDTH-1:1]};
      end else begin
         acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed mul/div unit for the execute stage.
// Works on magnitudes; sign and exceptions are applied at the end.
module multdiv_unit
   import multdiv_unit_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic            clock,
   input logic            reset,
   multdiv_unit_if.slave  bus
);

   localparam int AW = 2 * WIDTH;

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [AW-1:0]    step_acc, prod_s;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] abs_a, abs_b, quo_s;
   logic             sign_q, sign_d;
   logic             exc_q, exc_d;
   logic             sign_in, last, mult_ovf, div_ovf;

   multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
      .is_div (state_q == DIV),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc)
   );

   always_comb begin
      abs_a   = bus.data_operandA[WIDTH-1] ?
                -bus.data_operandA : bus.data_operandA;
      abs_b   = bus.data_operandB[WIDTH-1] ?
                -bus.data_operandB : bus.data_operandB;
      sign_in = bus.data_operandA[WIDTH-1] ^
                bus.data_operandB[WIDTH-1];
      last    = (cnt_q == CNT_W'(WIDTH - 1));
      // Signed product fits only if the top WIDTH+1 bits agree.
      prod_s   = sign_q ? -step_acc : step_acc;
      mult_ovf = !((&prod_s[AW-1:WIDTH-1]) ||
                   !(|prod_s[AW-1:WIDTH-1]));
      quo_s    = sign_q ? -step_acc[WIDTH-1:0] :
                 step_acc[WIDTH-1:0];
      div_ovf  = !sign_q && step_acc[WIDTH-1];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      sign_d  = sign_q;
      res_d   = res_q;
      exc_d   = exc_q;
      if (bus.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               state_d = IDLE;
               cnt_d   = '0;
               if (bus.ctrl_mult) begin
                  state_d = MULT;
                  acc_d   = {{WIDTH{1'b0}}, abs_b};
                  opnd_d  = abs_a;
                  sign_d  = sign_in;
               end else if (bus.ctrl_div) begin
                  sign_d = sign_in;
                  if (abs_b == '0) begin
                     state_d = DONE;
                     res_d   = '0;
                     exc_d   = 1'b1;
                  end else begin
                     state_d = DIV;
                     acc_d   = {{WIDTH{1'b0}}, abs_a};
                     opnd_d  = abs_b;
                  end
               end
            end
            MULT: begin
               acc_d = step_acc;
               cnt_d = cnt_q + 1'b1;
               if (last) begin
                  state_d = DONE;
                  res_d   = prod_s[WIDTH-1:0];
                  exc_d   = mult_ovf;
               end
            end
            DIV: begin
               acc_d = step_acc;
               cnt_d = cnt_q + 1'b1;
               if (last) begin
                  state_d = DONE;
                  res_d   = div_ovf ? '0 : quo_s;
                  exc_d   = div_ovf;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         sign_q  <= 1'b0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         sign_q  <= sign_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end

   assign bus.data_result    = res_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = (state_q == DONE);
   assign bus.busy = (state_q == MULT) || (state_q == DIV);

endmodule
